// File: rtl/aes_package.sv
// Shared AES definitions: datapath width, arbiter FSM encoding and default watchdog limit.
package aes_package;
  localparam int DATA_WIDTH              = 128;
  localparam int AES_ARB_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } arb_state_t;
endpackage

// File: rtl/aes_req_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping to 0.
module aes_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);
  localparam int IW = ID_W + 1;

  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + IW'(i);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      if (!any_grant && req[idx[ID_W-1:0]]) begin
        any_grant = 1'b1;
        grant_id  = idx[ID_W-1:0];
      end
    end
    if (any_grant) grant[grant_id] = 1'b1;
  end
endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core between NUM_REQ requesters with round-robin grant,
// registered operands, single start pulse, done capture and a watchdog abort.
//
// state | meaning
// IDLE  | waiting for a request, grant shown on req_ready
// ISSUE | operands latched, aes_start pulsed, watchdog cleared
// BUSY  | waiting for aes_done or watchdog expiry
// RESP  | result held on resp_* until the owner takes it
module aes_req_arbiter
  import aes_package::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = AES_ARB_TIMEOUT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_plaintext,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_key,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic                          aes_start,
  output logic [DATA_WIDTH-1:0]         aes_plaintext,
  output logic [DATA_WIDTH-1:0]         aes_key,
  input  logic [DATA_WIDTH-1:0]         aes_cyphertext,
  input  logic                          aes_done,
  output logic                          busy
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t         state, state_next;
  logic [ID_W-1:0]    rr_ptr, cur_id, grant_id;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [CNT_W-1:0]   cnt;

  aes_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    req_ready  = '0;
    resp_valid = '0;
    aes_start  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (any_grant) state_next = ISSUE;
      end
      ISSUE: begin
        aes_start  = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        // done has priority over a watchdog expiry in the same cycle
        if (aes_done || cnt == CNT_LAST) state_next = RESP;
      end
      RESP: begin
        resp_valid[cur_id] = 1'b1;
        if (resp_ready[cur_id]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cur_id        <= '0;
      cnt           <= '0;
      aes_plaintext <= '0;
      aes_key       <= '0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (any_grant) begin
            aes_plaintext <= req_plaintext[grant_id*DATA_WIDTH +: DATA_WIDTH];
            aes_key       <= req_key[grant_id*DATA_WIDTH +: DATA_WIDTH];
            cur_id        <= grant_id;
          end
        end
        ISSUE: cnt <= '0;
        BUSY: begin
          if (aes_done) begin
            resp_data <= aes_cyphertext;
            resp_err  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[cur_id])
            rr_ptr <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a latency-programmable AES stand-in.
module tb_aes_req_arbiter;
  localparam int DW = 128;
  localparam int TO = 64;

  localparam logic [DW-1:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [DW-1:0] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DW-1:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [DW-1:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [DW-1:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [2*DW-1:0] req_plaintext, req_key;
  logic [DW-1:0] resp_data, aes_plaintext, aes_key, aes_cyphertext;
  logic          resp_err, aes_start, aes_done, busy;

  int tests = 0;
  int fails = 0;

  aes_req_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_plaintext  (req_plaintext),
    .req_key        (req_key),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .aes_start      (aes_start),
    .aes_plaintext  (aes_plaintext),
    .aes_key        (aes_key),
    .aes_cyphertext (aes_cyphertext),
    .aes_done       (aes_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // AES stand-in: known FIPS-197 pairs, one-cycle done pulse model_lat cycles after start is seen
  bit model_en = 1'b1;
  int model_lat = 1;
  bit run_m = 1'b0;
  int cnt_m = 0;

  function automatic logic [DW-1:0] lookup(input logic [DW-1:0] k, input logic [DW-1:0] p);
    if (k == KA && p == PA) return CA;
    if (k == KB && p == PB) return CB;
    return k ^ p ^ 128'hdeadbeef;
  endfunction

  initial begin
    aes_done       = 1'b0;
    aes_cyphertext = '0;
  end

  always @(posedge clk) begin
    aes_done <= 1'b0;
    if (aes_start && model_en) begin
      run_m <= 1'b1;
      cnt_m <= model_lat;
    end else if (run_m) begin
      if (cnt_m <= 1) begin
        aes_done       <= 1'b1;
        aes_cyphertext <= lookup(aes_key, aes_plaintext);
        run_m          <= 1'b0;
      end else begin
        cnt_m <= cnt_m - 1;
      end
    end
  end

  typedef struct {
    bit            rst_first;
    logic [1:0]    valid;
    bit            en;
    int            lat;
    int            id;
    logic [DW-1:0] exp_ct;
    bit            exp_err;
    int            hold;
    int            exp_wait;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restore_data();
    req_key       = {KB, KA};
    req_plaintext = {PB, PA};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_aes_start", aes_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_aes_key", aes_key, 0);
    chk("rst_aes_pt", aes_plaintext, 0);
    rst = 1'b1;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int n;
    logic [1:0] oh;
    logic [DW-1:0] ek, ep;
    oh = 2'b01 << v.id;
    ek = (v.id == 0) ? KA : KB;
    ep = (v.id == 0) ? PA : PB;
    if (v.rst_first) do_reset();
    model_en   = v.en;
    model_lat  = v.lat;
    req_valid  = v.valid;
    resp_ready = '0;
    #1;
    n = 0;
    while (req_ready == 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (req_ready == 0) begin
      chk({tag, "_grant_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_req_ready"}, req_ready, oh);
    @(negedge clk);
    // requester is free to change its inputs once accepted
    req_key[v.id*DW +: DW]       = ~ek;
    req_plaintext[v.id*DW +: DW] = ~ep;
    chk({tag, "_aes_start"}, aes_start, 1);
    chk({tag, "_issue_ready"}, req_ready, 0);
    chk({tag, "_issue_busy"}, busy, 1);
    chk({tag, "_aes_key"}, aes_key, ek);
    chk({tag, "_aes_pt"}, aes_plaintext, ep);
    @(negedge clk);
    chk({tag, "_start_pulse"}, aes_start, 0);
    n = 1;
    while (resp_valid == 0 && n < 200) begin
      @(negedge clk); n++;
    end
    if (resp_valid == 0) begin
      chk({tag, "_resp_timeout"}, 0, 1);
      restore_data();
      return;
    end
    chk({tag, "_latency"}, DW'(n), DW'(v.exp_wait));
    chk({tag, "_resp_valid"}, resp_valid, oh);
    chk({tag, "_resp_data"}, resp_data, v.exp_ct);
    chk({tag, "_resp_err"}, resp_err, v.exp_err);
    restore_data();
    for (int h = 0; h < v.hold; h++) begin
      resp_ready = ~oh;
      @(negedge clk);
      chk({tag, "_hold_valid"}, resp_valid, oh);
      chk({tag, "_hold_data"}, resp_data, v.exp_ct);
      chk({tag, "_hold_ready"}, req_ready, 0);
      chk({tag, "_hold_busy"}, busy, 1);
    end
    resp_ready = oh;
    #1;
    chk({tag, "_hs_no_grant"}, req_ready, 0);
    @(negedge clk);
    chk({tag, "_resp_drop"}, resp_valid, 0);
    resp_ready = '0;
  endtask

  vec_t tbl[12];

  initial begin
    bit seen;
    vec_t v;
    rst = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    restore_data();

    //         rst  valid  en lat id  ct  err hold wait
    tbl[0]  = '{1, 2'b01, 1, 3,  0, CA, 0, 0,  5};
    tbl[1]  = '{1, 2'b11, 1, 2,  0, CA, 0, 0,  4};
    tbl[2]  = '{0, 2'b11, 1, 5,  1, CB, 0, 0,  7};
    tbl[3]  = '{0, 2'b11, 1, 1,  0, CA, 0, 0,  3};
    tbl[4]  = '{0, 2'b11, 1, 4,  1, CB, 0, 0,  6};
    tbl[5]  = '{0, 2'b11, 1, 2,  0, CA, 0, 10, 4};
    tbl[6]  = '{0, 2'b11, 1, 2,  1, CB, 0, 0,  4};
    tbl[7]  = '{0, 2'b01, 0, 1,  0, '0, 1, 0,  TO + 1};
    tbl[8]  = '{0, 2'b01, 1, 2,  0, CA, 0, 0,  4};
    tbl[9]  = '{0, 2'b10, 1, TO - 1, 1, CB, 0, 0, TO + 1};
    tbl[10] = '{0, 2'b01, 1, TO, 0, '0, 1, 0,  TO + 1};
    tbl[11] = '{0, 2'b10, 1, 2,  1, CB, 0, 0,  4};

    for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("v%0d", i));

    // reset during BUSY: silent abort, late done ignored, pointer back to 0
    do_reset();
    model_en  = 1'b1;
    model_lat = 10;
    req_valid = 2'b10;
    #1;
    chk("mid_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("mid_in_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_resp", resp_valid, 0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid != 0 || busy) seen = 1'b1;
    end
    chk("mid_late_done_ignored", seen, 0);
    v = '{0, 2'b11, 1, 2, 0, CA, 0, 0, 4};
    run_op(v, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, failed %0d", fails);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
- Shares one aes encryption instance between NUM_REQ requesters.
- Round-robin selection; per-requester valid/ready request and response handshakes.
- Holds plaintext and key stable in registers for the whole operation, because key expansion is combinational.
- Sequences the single start pulse, waits for done, and returns the ciphertext to the originating requester. A watchdog reports a hung core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, max cycles from aes_start to aes_done before abort.
- ID_W, $clog2(NUM_REQ) (min 1), requester index width (derived, localparam).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_plaintext  in  NUM_REQ x DATA_WIDTH  packed plaintext per requester
- req_key  in  NUM_REQ x DATA_WIDTH  packed key per requester
- resp_valid  out  NUM_REQ  result available for requester i
- resp_ready  in  NUM_REQ  requester i consumes result
- resp_data  out  DATA_WIDTH  ciphertext, shared bus, valid with resp_valid
- resp_err  out  1  qualifies resp_data: 1 = timeout abort, data forced to 0
- aes_start  out  1  one-cycle start to aes
- aes_plaintext  out  DATA_WIDTH  registered plaintext to aes
- aes_key  out  DATA_WIDTH  registered key to aes
- aes_cyphertext  in  DATA_WIDTH  result from aes
- aes_done  in  1  aes completion
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: rst==0 at a clk edge is sampled synchronously and forces the following values.
  - state=IDLE, rr_ptr=0, cur_id=0, timeout counter=0.
  - aes_plaintext=0, aes_key=0, resp_data=0, resp_err=0.
  - All outputs low: req_ready, resp_valid, aes_start, busy.
  - Reset mid-operation aborts silently: no response is issued. A late aes_done is ignored in IDLE.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - The grant is the first requester with req_valid set, searching from rr_ptr upward and wrapping at NUM_REQ-1 -> 0.
  - req_ready[g]=1 combinationally for the granted index only.
  - On that edge, latch req_plaintext[g], req_key[g] and cur_id=g, then go to ISSUE.
  - No valid requesters: stay in IDLE, all req_ready low.
- ISSUE: aes_start=1 for exactly one cycle, clear the timeout counter, go to BUSY.
- BUSY:
  - aes_done==1: capture aes_cyphertext into resp_data, set resp_err=0, go to RESP. The first done cycle is used; done may be a pulse or a level.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no done: resp_data=0, resp_err=1, go to RESP.
  - If done and the timeout coincide, done wins.
- RESP:
  - resp_valid[cur_id]=1; all other bits are 0.
  - resp_data and resp_err are held until resp_ready[cur_id]=1.
  - On that handshake: go to IDLE and set rr_ptr=(cur_id+1) mod NUM_REQ. resp_valid drops the next cycle.
  - resp_ready bits of other requesters are ignored.
- Throughput: one operation at a time; the next grant is no earlier than the cycle after the response handshake.
- Latency:
  - Accept at edge T -> aes_start high in cycle T+1.
  - aes_done first high in cycle T+1+L -> resp_valid high from T+2+L.
- Stability:
  - aes_plaintext and aes_key change only on a grant edge.
  - Requesters may change inputs freely after their req_ready handshake.
- A requester holding req_valid while not granted is never dropped. Round-robin bounds its wait to NUM_REQ-1 other operations.
- Fairness: a requester that deasserts req_valid before being granted loses its turn with no side effects.

Decomposition:
- Shared package (aes_package) additions:
  - DATA_WIDTH, already present.
  - arb_state_t enum {IDLE, ISSUE, BUSY, RESP}.
  - AES_ARB_TIMEOUT_DEFAULT=64.
- Sub-module aes_rr_arbiter, combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Instantiated once. The FSM and registers live in aes_req_arbiter.

Test Plan:
- Single request: reset, then req_valid=01, key 000102..0f, pt 00112233..ff -> req_ready[0] one cycle, aes_start one cycle later, resp_valid[0] with resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, resp_err=0.
- Contention: both requesters valid continuously, 4 ops, rr_ptr=0 at start -> grant order 0,1,0,1; each response routed to the correct resp_valid bit with its own FIPS-197 vector.
- Backpressure: hold resp_ready[0]=0 for 10 cycles in RESP -> resp_valid and resp_data stable, req_ready stays 0 for requester 1, busy=1; release -> next grant to 1.
- Timeout: model never asserts aes_done -> after TIMEOUT_CYCLES in BUSY, resp_valid=1, resp_err=1, resp_data=0; the next request completes normally.
- Done on timeout edge: aes_done asserted exactly in the final counter cycle -> resp_err=0, ciphertext delivered.
- Reset mid-BUSY: drive rst=0 for one cycle during BUSY, then a late aes_done -> no resp_valid, busy=0, rr_ptr=0, and the next request proceeds normally.
